// File: rtl/cpu_pkg.sv
// Shared constants and types for the two-stage RV32 core: opcodes, funct fields,
// ALU operation encoding and the memory-mapped I/O CSR addresses.
package cpu_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_ADD   = 3'b000;
    localparam logic [2:0] F3_SLL   = 3'b001;
    localparam logic [2:0] F3_SLT   = 3'b010;
    localparam logic [2:0] F3_SLTU  = 3'b011;
    localparam logic [2:0] F3_XOR   = 3'b100;
    localparam logic [2:0] F3_SR    = 3'b101;
    localparam logic [2:0] F3_OR    = 3'b110;
    localparam logic [2:0] F3_AND   = 3'b111;
    localparam logic [2:0] F3_MUL   = 3'b000;
    localparam logic [2:0] F3_MULH  = 3'b001;
    localparam logic [2:0] F3_MULHU = 3'b011;
    localparam logic [2:0] F3_CSRRW = 3'b001;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [11:0] CSR_IO0_ADDR = 12'hF00;
    localparam logic [11:0] CSR_IO2_ADDR = 12'hF02;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_MUL,
        ALU_MULH,
        ALU_MULHU,
        ALU_LUI
    } alu_op_t;

endpackage

// File: rtl/execute_wb_alu.sv
// Combinational integer ALU with 32x32 multiply; LUI passes the pre-shifted
// immediate through on operand b.
module alu
    import cpu_pkg::*;
(
    input  alu_op_t          op,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic [XLEN-1:0]  result
);

    localparam int unsigned SHW = 5;

    logic [SHW-1:0]    shamt;
    logic [2*XLEN-1:0] prod_uu;
    logic [XLEN-1:0]   mulhu_c;
    logic [XLEN-1:0]   mulh_c;

    assign shamt   = b[SHW-1:0];
    assign prod_uu = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    assign mulhu_c = prod_uu[2*XLEN-1:XLEN];
    // Signed high word from the unsigned one: subtract b (a, resp.) when a (b) is negative.
    assign mulh_c  = mulhu_c - (a[XLEN-1] ? b : '0) - (b[XLEN-1] ? a : '0);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_SLL:   result = a << shamt;
            ALU_SLT:   result = XLEN'($signed(a) < $signed(b));
            ALU_SLTU:  result = XLEN'(a < b);
            ALU_XOR:   result = a ^ b;
            ALU_SRL:   result = a >> shamt;
            ALU_SRA:   result = $signed(a) >>> shamt;
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
            ALU_MUL:   result = prod_uu[XLEN-1:0];
            ALU_MULH:  result = mulh_c;
            ALU_MULHU: result = mulhu_c;
            ALU_LUI:   result = b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/execute_wb.sv
// Execute/writeback stage: decode to ALU op, WB->EX forwarding, I/O CSRs and the
// registered register-file write port.
module execute_wb
    import cpu_pkg::*;
#(
    parameter logic [11:0] CSR_IO0 = CSR_IO0_ADDR,
    parameter logic [11:0] CSR_IO2 = CSR_IO2_ADDR
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      opcode_EX,
    input  logic [4:0]      rd_EX,
    input  logic [2:0]      funct3_EX,
    input  logic [4:0]      rs1_EX,
    input  logic [4:0]      rs2_EX,
    input  logic [6:0]      funct7_EX,
    input  logic [11:0]     imm12_EX,
    input  logic [19:0]     imm20_EX,
    input  logic [11:0]     csr_EX,
    input  logic [XLEN-1:0] readdata1,
    input  logic [XLEN-1:0] readdata2,
    input  logic [XLEN-1:0] io0_in,
    output logic            regwrite_WB,
    output logic [4:0]      rd_WB,
    output logic [XLEN-1:0] writedata_WB,
    output logic [XLEN-1:0] io2_out
);

    localparam int unsigned IMM12_W = 12;

    alu_op_t         alu_op;
    logic            op_valid;
    logic            use_imm;
    logic            sel_io0;
    logic            sel_io2;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] alu_b;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] ex_result;

    // x0 is excluded so a stale rd_WB of zero can never shadow the register file.
    assign fwd_a = (regwrite_WB && rd_WB != 5'd0 && rd_WB == rs1_EX) ? writedata_WB : readdata1;
    assign fwd_b = (regwrite_WB && rd_WB != 5'd0 && rd_WB == rs2_EX) ? writedata_WB : readdata2;

    // Instruction decode; anything unmatched leaves op_valid low and becomes a bubble.
    always_comb begin
        alu_op   = ALU_ADD;
        op_valid = 1'b0;
        use_imm  = 1'b0;
        sel_io0  = 1'b0;
        sel_io2  = 1'b0;
        case (opcode_EX)
            OP_RTYPE: begin
                case (funct7_EX)
                    F7_BASE: begin
                        op_valid = 1'b1;
                        case (funct3_EX)
                            F3_ADD:  alu_op = ALU_ADD;
                            F3_SLL:  alu_op = ALU_SLL;
                            F3_SLT:  alu_op = ALU_SLT;
                            F3_SLTU: alu_op = ALU_SLTU;
                            F3_XOR:  alu_op = ALU_XOR;
                            F3_SR:   alu_op = ALU_SRL;
                            F3_OR:   alu_op = ALU_OR;
                            default: alu_op = ALU_AND;
                        endcase
                    end
                    F7_ALT: begin
                        if (funct3_EX == F3_ADD) begin
                            op_valid = 1'b1;
                            alu_op   = ALU_SUB;
                        end else if (funct3_EX == F3_SR) begin
                            op_valid = 1'b1;
                            alu_op   = ALU_SRA;
                        end
                    end
                    F7_MULDIV: begin
                        if (funct3_EX == F3_MUL) begin
                            op_valid = 1'b1;
                            alu_op   = ALU_MUL;
                        end else if (funct3_EX == F3_MULH) begin
                            op_valid = 1'b1;
                            alu_op   = ALU_MULH;
                        end else if (funct3_EX == F3_MULHU) begin
                            op_valid = 1'b1;
                            alu_op   = ALU_MULHU;
                        end
                    end
                    default: op_valid = 1'b0;
                endcase
            end
            OP_ITYPE: begin
                op_valid = 1'b1;
                use_imm  = 1'b1;
                case (funct3_EX)
                    F3_ADD:  alu_op = ALU_ADD;
                    F3_SLL:  alu_op = ALU_SLL;
                    F3_SLT:  alu_op = ALU_SLT;
                    F3_SLTU: alu_op = ALU_SLTU;
                    F3_XOR:  alu_op = ALU_XOR;
                    F3_SR:   alu_op = imm12_EX[10] ? ALU_SRA : ALU_SRL;
                    F3_OR:   alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
            OP_LUI: begin
                op_valid = 1'b1;
                alu_op   = ALU_LUI;
            end
            OP_SYSTEM: begin
                if (funct3_EX == F3_CSRRW) begin
                    if (csr_EX == CSR_IO0) begin
                        op_valid = 1'b1;
                        sel_io0  = 1'b1;
                    end else if (csr_EX == CSR_IO2) begin
                        op_valid = 1'b1;
                        sel_io2  = 1'b1;
                    end
                end
            end
            default: op_valid = 1'b0;
        endcase
    end

    always_comb begin
        alu_b = fwd_b;
        if (opcode_EX == OP_LUI) begin
            alu_b = {imm20_EX, 12'b0};
        end else if (use_imm) begin
            alu_b = {{(XLEN-IMM12_W){imm12_EX[IMM12_W-1]}}, imm12_EX};
        end
    end

    alu u_alu (
        .op     (alu_op),
        .a      (fwd_a),
        .b      (alu_b),
        .result (alu_result)
    );

    // csrrw to IO2 returns the display value from before this instruction's write.
    assign ex_result = sel_io0 ? io0_in : (sel_io2 ? io2_out : alu_result);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regwrite_WB  <= 1'b0;
            rd_WB        <= 5'd0;
            writedata_WB <= '0;
            io2_out      <= '0;
        end else begin
            regwrite_WB  <= op_valid && (rd_EX != 5'd0);
            rd_WB        <= rd_EX;
            writedata_WB <= ex_result;
            if (sel_io2) begin
                io2_out <= fwd_a;
            end
        end
    end

endmodule

// File: doc/execute_wb.md
# execute_wb

Execute and writeback stage of the two-stage RV32 core. It consumes the decoded instruction fields and the two register-file read ports produced during EX, and computes the integer ALU, multiply, LUI or CSR-I/O result. The result is registered into a writeback (WB) register that drives the register-file write port one cycle later. The block forwards the WB result back into EX operands and owns the switch-input and display-output CSRs.

## Interface
Parameters:
- `CSR_IO0`, default `12'hF00`: CSR address that reads the switch input.
- `CSR_IO2`, default `12'hF02`: CSR address that writes the display output.

Ports:
- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `opcode_EX`  in  7  decoded opcode.
- `rd_EX`  in  5  destination register.
- `funct3_EX`  in  3  funct3 field.
- `rs1_EX`, `rs2_EX`  in  5 each  source register addresses, used for forwarding.
- `funct7_EX`  in  7  funct7 field.
- `imm12_EX`  in  12  I-type immediate.
- `imm20_EX`  in  20  U-type immediate.
- `csr_EX`  in  12  CSR address.
- `readdata1`, `readdata2`  in  32 each  register-file read data.
- `io0_in`  in  32  switch value, zero-extended from `SW[17:0]` by the parent.
- `regwrite_WB`  out  1  register-file write enable.
- `rd_WB`  out  5  register-file write address.
- `writedata_WB`  out  32  register-file write data.
- `io2_out`  out  32  display register.

## Operation
Operand forwarding:
- `A = (regwrite_WB && rd_WB!=0 && rd_WB==rs1_EX) ? writedata_WB : readdata1`.
- `B` is formed the same way from `rs2_EX` and `readdata2`.
- `x0` is never forwarded.

Supported instructions:
- R-type, opcode `0110011`, `funct7` `0000000`: `add`, `sll`, `slt`, `sltu`, `xor`, `srl`, `or`, `and`.
- R-type, `funct7` `0100000`: `sub`, `sra`.
- R-type, `funct7` `0000001`: `mul` (funct3 000, low 32 bits of the product), `mulh` (001, signed×signed, high 32 bits), `mulhu` (011, unsigned×unsigned, high 32 bits).
- I-type, opcode `0010011`: `addi`, `slti`, `sltiu`, `xori`, `ori`, `andi` use `imm12` sign-extended to 32 bits. `slli`, `srli`, `srai` use `imm12[4:0]` as the shift amount, and `imm12[10]` selects `srai`.
- LUI, opcode `0110111`: result is `{imm20, 12'b0}`.
- `csrrw`, opcode `1110011`, funct3 `001`:
  - `csr==CSR_IO0`: rd receives `io0_in`.
  - `csr==CSR_IO2`: `io2_out` is loaded with `A`, and rd receives the old `io2_out`.
  - Any other CSR: no rd write and no side effect.

Arithmetic rules:
- All arithmetic is modulo 2^32. Shift amounts are the low 5 bits of the operand.
- `slt` and `sltu` produce 0 or 1.

Writeback control:
- Any opcode or funct combination outside the list above is a bubble: `regwrite_WB` is 0 next cycle. This includes the all-zero instruction issued after reset.
- `rd_EX==0` forces `regwrite_WB` to 0 for all instructions. A `csrrw` to `CSR_IO2` still updates `io2_out`.

## Timing
- Result latency is 1 cycle. The instruction in EX during cycle n appears on the WB outputs in cycle n+1, and the register file commits it at the end of cycle n+1.
- A back-to-back dependent instruction gets its operand by forwarding, with no stall. A dependency two instructions back reads the register file directly; the register file commits at the edge, and no write-through is needed.
- `io2_out` updates on the clock edge that ends the `csrrw` EX cycle.
- The `io0_in` value is sampled during EX.
- On `rst_n` low, asynchronously and immediately: `regwrite_WB=0`, `rd_WB=0`, `writedata_WB=0`, `io2_out=0`. An instruction in flight when reset asserts is discarded.
- After `rst_n` rises, the first edge captures whatever is in EX. Reset EX is all zero, which is a bubble.
- The stage never stalls and has no valid handshake: every cycle is an instruction or a bubble.

## Structure
- `cpu_pkg` holds:
  - opcode constants `OP_RTYPE`, `OP_ITYPE`, `OP_LUI`, `OP_SYSTEM`;
  - funct3 and funct7 constants;
  - the `alu_op_t` enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, MUL, MULH, MULHU, LUI);
  - CSR address constants.
- Sub-module `alu` is combinational: `alu_op_t`, `A`, `B` in, 32-bit result out. The decode-to-`alu_op_t` logic, forwarding muxes, CSR logic and WB registers stay in `execute_wb`.

## Test plan
- Reset and ordering:
  - Assert `rst_n` low mid-cycle → all outputs 0 immediately, without a clock edge.
  - Release, then issue `addi x1,x0,5` → next cycle `regwrite_WB=1`, `rd_WB=1`, `writedata_WB=5`.
- Forwarding:
  - `addi x1,x0,5` then `add x2,x1,x1` with `readdata1`/`readdata2` held at stale 0 → second result 10.
  - Same sequence with `rd=x0` on the first instruction → no write, and no forward.
- Arithmetic edges:
  - `sub` with A=0, B=1 → `32'hFFFFFFFF`.
  - `sra` of `32'h80000000` by 4 → `32'hF8000000`.
  - `sltu` with A=1, B=`32'hFFFFFFFF` → 1; `slt` on the same operands → 0.
  - `slli` by 31 of 1 → `32'h80000000`.
- Multiply:
  - `mulh` of `32'h80000000` by itself → `32'h40000000`.
  - `mulhu` of `32'hFFFFFFFF` by itself → `32'hFFFFFFFE`.
  - `mul` of 7 and -3 → `32'hFFFFFFEB`.
- CSR:
  - `io0_in=32'h0002A5A5`, `csrrw x3,0xF00,x0` → `writedata_WB=32'h0002A5A5`.
  - `csrrw x4,0xF02,x1` with x1=`32'h12345678` → `io2_out=32'h12345678`, and x4 gets the old value 0.
- Bubbles:
  - Opcode 0 → `regwrite_WB=0`.
  - `lui x5,0xABCDE` → `writedata_WB=32'hABCDE000`.
  - Unknown CSR `0x300` → no write, and `io2_out` unchanged.
